// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter and sequencer for a single-port memory.
// Each accepted command becomes a one-cycle enable; reads return one registered response.
module mem_arbiter #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid_0,
  input  logic              req_valid_1,
  output logic              req_ready_0,
  output logic              req_ready_1,
  input  logic              req_rd_wr_0,
  input  logic              req_rd_wr_1,
  input  logic [ADDR_W-1:0] req_addr_0,
  input  logic [ADDR_W-1:0] req_addr_1,
  input  logic [DATA_W-1:0] req_wdata_0,
  input  logic [DATA_W-1:0] req_wdata_1,
  output logic              rsp_valid_0,
  output logic              rsp_valid_1,
  output logic [DATA_W-1:0] rsp_rdata_0,
  output logic [DATA_W-1:0] rsp_rdata_1,
  output logic              mem_enb,
  output logic              mem_rd_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, CMD, CAPT} state_e;

  state_e              state_q, state_d;
  logic                last_grant_q, last_grant_d;
  logic                owner_q, owner_d;
  logic                mem_enb_q, mem_enb_d;
  logic                mem_rd_wr_q, mem_rd_wr_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                rsp_valid_0_q, rsp_valid_0_d;
  logic                rsp_valid_1_q, rsp_valid_1_d;
  logic [DATA_W-1:0]   rsp_rdata_0_q, rsp_rdata_0_d;
  logic [DATA_W-1:0]   rsp_rdata_1_q, rsp_rdata_1_d;

  logic grant_0, grant_1, accept, sel;

  // On contention the requester that did not win last time gets the port.
  always_comb begin
    grant_0     = req_valid_0 && (!req_valid_1 || last_grant_q);
    grant_1     = req_valid_1 && (!req_valid_0 || !last_grant_q);
    req_ready_0 = (state_q == IDLE) && grant_0;
    req_ready_1 = (state_q == IDLE) && grant_1;
    accept      = req_ready_0 || req_ready_1;
    sel         = req_ready_1;
  end

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    owner_d       = owner_q;
    mem_enb_d     = 1'b0;
    mem_rd_wr_d   = mem_rd_wr_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    rsp_valid_0_d = 1'b0;
    rsp_valid_1_d = 1'b0;
    rsp_rdata_0_d = rsp_rdata_0_q;
    rsp_rdata_1_d = rsp_rdata_1_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d      = CMD;
          mem_enb_d    = 1'b1;
          mem_rd_wr_d  = sel ? req_rd_wr_1 : req_rd_wr_0;
          mem_addr_d   = sel ? req_addr_1  : req_addr_0;
          mem_wdata_d  = sel ? req_wdata_1 : req_wdata_0;
          owner_d      = sel;
          last_grant_d = sel;
        end
      end
      CMD: begin
        state_d = mem_rd_wr_q ? CAPT : IDLE;
      end
      CAPT: begin
        // mem_rdata is only trusted here, the cycle after the read-enable edge.
        state_d = IDLE;
        if (owner_q) begin
          rsp_valid_1_d = 1'b1;
          rsp_rdata_1_d = mem_rdata;
        end else begin
          rsp_valid_0_d = 1'b1;
          rsp_rdata_0_d = mem_rdata;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      last_grant_q  <= 1'b1;
      owner_q       <= 1'b0;
      mem_enb_q     <= 1'b0;
      mem_rd_wr_q   <= 1'b1;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      rsp_valid_0_q <= 1'b0;
      rsp_valid_1_q <= 1'b0;
      rsp_rdata_0_q <= '0;
      rsp_rdata_1_q <= '0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      owner_q       <= owner_d;
      mem_enb_q     <= mem_enb_d;
      mem_rd_wr_q   <= mem_rd_wr_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      rsp_valid_0_q <= rsp_valid_0_d;
      rsp_valid_1_q <= rsp_valid_1_d;
      rsp_rdata_0_q <= rsp_rdata_0_d;
      rsp_rdata_1_q <= rsp_rdata_1_d;
    end
  end

  assign mem_enb     = mem_enb_q;
  assign mem_rd_wr   = mem_rd_wr_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign rsp_valid_0 = rsp_valid_0_q;
  assign rsp_valid_1 = rsp_valid_1_q;
  assign rsp_rdata_0 = rsp_rdata_0_q;
  assign rsp_rdata_1 = rsp_rdata_1_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer in front of the single-port `mem` block.
- Shares the one memory port between two masters, for example a CPU-side port and a DMA/test port.
- Converts each accepted valid/ready request into a one-cycle `mem` enable pulse with registered address, data and direction.
- For reads, captures `mem` data on the cycle it is valid and returns it to the owning requester as a one-cycle response.

Parameters:
- ADDR_W, 9, address width; 9 bits gives the 512-entry memory.
- DATA_W, 8, data width; must match the `mem` data width.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid_0 / req_valid_1  in  1  requester has a command pending.
- req_ready_0 / req_ready_1  out  1  command accepted on an edge where valid&&ready is high.
- req_rd_wr_0 / req_rd_wr_1  in  1  1=read, 0=write; same encoding as `mem`.
- req_addr_0 / req_addr_1  in  ADDR_W  target address.
- req_wdata_0 / req_wdata_1  in  DATA_W  write data; ignored for reads.
- rsp_valid_0 / rsp_valid_1  out  1  one-cycle pulse: read data valid.
- rsp_rdata_0 / rsp_rdata_1  out  DATA_W  read data; holds its value until the next response to that port.
- mem_enb  out  1  drives `mem` enb.
- mem_rd_wr  out  1  drives `mem` rd_wr.
- mem_addr  out  ADDR_W  drives `mem` addr.
- mem_wdata  out  DATA_W  drives `mem` data_in.
- mem_rdata  in  DATA_W  from `mem` data_out.
  - Valid only in the cycle after a read-enable edge.
  - High-Z/don't-care at all other times.
- busy  out  1  high whenever state != IDLE.

Behaviour:

Reset values (asynchronous, while rst_n=0):
- state=IDLE, last_grant=1 (requester 0 wins first).
- mem_enb=0, mem_rd_wr=1, mem_addr=0, mem_wdata=0.
- rsp_valid_*=0, rsp_rdata_*=0, busy=0.
- Holding rst_n=0 also resets `mem`; its contents become 0x0A.

Arbitration (combinational, IDLE only):
- Only one valid: grant it.
- Both valid: grant the requester != last_grant.
- req_ready_x = (state==IDLE) && grant_x. The two readies are never both high.
- last_grant updates on the accept edge only.

Requester protocol:
- Once valid is high, it is held with addr/data/rd_wr stable until ready.
- Valid may not drop before acceptance.

FSM:
- IDLE → CMD on accept. Registers mem_rd_wr/mem_addr/mem_wdata from the granted port, sets mem_enb=1, and stores owner id.
- CMD, one cycle: mem_enb=1. `mem` samples at the end of CMD.
  - Write → IDLE. No response is issued; the write is complete at that edge.
  - Read → CAPT.
- CAPT, one cycle: mem_enb=0. At the end of CAPT:
  - rsp_rdata_owner <= mem_rdata;
  - rsp_valid_owner <= 1 for exactly one cycle;
  - → IDLE.
- mem_enb is high only in CMD.
- mem_rd_wr/addr/wdata hold their last issued values outside CMD.

Latency and throughput:
- Read: accept at edge E0; rsp_valid high in the cycle after E2. That is 3 cycles per read.
- Write: 2 cycles per write.
- No overlap: a new accept happens only in IDLE.
- A response pulse may coincide with the next accept; the cycle of the pulse is IDLE.

Boundary conditions:
- mem_rdata is sampled only at the end of CAPT; Z/X outside that window never reaches rsp_rdata.
- Address 0 and 2^ADDR_W-1 are both legal; there is no wrap or bounds logic.
- Write then read of the same address, from either port, returns the new data: ordering is strict, with no bypass needed.
- Under continuous contention, grants strictly alternate 0,1,0,1.
- Reset mid-operation (CMD or CAPT):
  - immediate return to IDLE with mem_enb=0;
  - the in-flight read is dropped with no rsp_valid;
  - an in-flight write may or may not land, which is irrelevant because `mem` reset refills 0x0A.
- Exactly one rsp_valid per accepted read; never one for a write.

Test Plan:
1. Reset, then port0 reads addr 0x005 → rsp_valid_0 pulses 3 cycles after accept with rsp_rdata_0=0x0A; rsp_valid_1 stays 0.
2. Port1 writes 0x3C to 0x1FF, then port1 reads 0x1FF → rsp_rdata_1=0x3C; mem_enb high exactly 1 cycle per command.
3. Both ports hold valid reads (p0: 0x010, p1: 0x020) after reset → p0 granted first, then p1. With valids kept high for 6 commands, grant order is 0,1,0,1,0,1.
4. Port0 writes 0x55 to 0x100 while port1 has a read of 0x100 pending → write granted first, and port1 read returns 0x55.
5. rst_n pulsed low during CAPT of a port0 read → mem_enb=0 and busy=0 immediately; no rsp_valid_0 pulse. A subsequent read of any address returns 0x0A.
6. Port0 valid held for 5 cycles while port1 owns a read → req_ready_0 stays 0 until the FSM returns to IDLE; the port0 command is then accepted exactly once.
